// File: rtl/register_bank_responder.sv
// Banked warp-register file read responder: round-robin read arbitration per bank,
// masked write-back with priority over reads, one-cycle registered read responses.
module register_bank_responder #(
    parameter int NumRequesters = 2,
    parameter int NumBanks      = 2,
    parameter int NumWarps      = 8,
    parameter int WarpWidth     = 32,
    parameter int RegIdxWidth   = 6,
    parameter int RegWidth      = 32,
    localparam int WidWidth     = ($clog2(NumWarps) > 1) ? $clog2(NumWarps) : 1,
    localparam int BankSel      = $clog2(NumBanks)
) (
    input  logic                                        clk_i,
    input  logic                                        rst_i,
    input  logic [NumRequesters-1:0]                    req_valid_i,
    output logic [NumRequesters-1:0]                    req_ready_o,
    input  logic [NumRequesters*WidWidth-1:0]           req_wid_i,
    input  logic [NumRequesters*RegIdxWidth-1:0]        req_reg_idx_i,
    output logic [NumRequesters-1:0]                    rsp_valid_o,
    output logic [NumRequesters*RegWidth*WarpWidth-1:0] rsp_data_o,
    input  logic                                        wb_valid_i,
    output logic                                        wb_ready_o,
    input  logic [WidWidth-1:0]                         wb_wid_i,
    input  logic [RegIdxWidth-1:0]                      wb_reg_idx_i,
    input  logic [WarpWidth-1:0]                        wb_act_mask_i,
    input  logic [RegWidth*WarpWidth-1:0]               wb_data_i
);

    localparam int BankIdxW  = (BankSel > 0) ? BankSel : 1;
    localparam int RowBits   = WidWidth + RegIdxWidth - BankSel;
    localparam int BankDepth = 2 ** RowBits;
    localparam int DataW     = RegWidth * WarpWidth;
    localparam int PtrW      = (NumRequesters > 1) ? $clog2(NumRequesters) : 1;

    // The bank index comes from (wid + reg_idx), so inside a bank the row is
    // {wid, reg_idx without its low BankSel bits}, which is unique per register.
    function automatic logic [BankIdxW-1:0] bank_of(input logic [WidWidth-1:0]    wid,
                                                     input logic [RegIdxWidth-1:0] idx);
        if (NumBanks == 1) return '0;
        return BankIdxW'({{RegIdxWidth{1'b0}}, wid} + {{WidWidth{1'b0}}, idx});
    endfunction

    function automatic logic [RowBits-1:0] row_of(input logic [WidWidth-1:0]    wid,
                                                   input logic [RegIdxWidth-1:0] idx);
        return RowBits'({wid, idx} >> BankSel);
    endfunction

    logic [DataW-1:0]            mem_q [NumBanks][BankDepth];
    logic [PtrW-1:0]             ptr_q [NumBanks];
    logic [PtrW-1:0]             ptr_d [NumBanks];
    logic [NumRequesters-1:0]    rsp_valid_q;
    logic [NumRequesters*DataW-1:0] rsp_data_q;

    logic [BankIdxW-1:0]         req_bank [NumRequesters];
    logic [RowBits-1:0]          req_row  [NumRequesters];
    logic [BankIdxW-1:0]         wb_bank;
    logic [RowBits-1:0]          wb_row;
    logic                        wb_fire;
    logic [NumRequesters-1:0]    grant;

    always_comb begin
        for (int r = 0; r < NumRequesters; r++) begin
            req_bank[r] = bank_of(req_wid_i[r*WidWidth +: WidWidth],
                                  req_reg_idx_i[r*RegIdxWidth +: RegIdxWidth]);
            req_row[r]  = row_of(req_wid_i[r*WidWidth +: WidWidth],
                                 req_reg_idx_i[r*RegIdxWidth +: RegIdxWidth]);
        end
    end

    assign wb_bank = bank_of(wb_wid_i, wb_reg_idx_i);
    assign wb_row  = row_of(wb_wid_i, wb_reg_idx_i);
    assign wb_fire = wb_valid_i & ~rst_i;

    // A bank claimed by the write-back grants no read; otherwise scan requesters
    // starting at the bank pointer and take the first one aimed at this bank.
    always_comb begin
        grant = '0;
        for (int b = 0; b < NumBanks; b++) begin
            logic found;
            int   idx;
            found    = 1'b0;
            idx      = 0;
            ptr_d[b] = ptr_q[b];
            if (!(wb_fire && wb_bank == BankIdxW'(b))) begin
                for (int i = 0; i < NumRequesters; i++) begin
                    idx = int'(ptr_q[b]) + i;
                    if (idx >= NumRequesters) idx = idx - NumRequesters;
                    if (!found && req_valid_i[idx] && req_bank[idx] == BankIdxW'(b)) begin
                        found      = 1'b1;
                        grant[idx] = 1'b1;
                        ptr_d[b]   = (idx == NumRequesters - 1) ? '0 : PtrW'(idx + 1);
                    end
                end
            end
        end
    end

    assign req_ready_o = grant & {NumRequesters{~rst_i}};
    assign wb_ready_o  = ~rst_i;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int b = 0; b < NumBanks; b++) ptr_q[b] <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
        end else begin
            for (int b = 0; b < NumBanks; b++) ptr_q[b] <= ptr_d[b];
            rsp_valid_q <= grant;
            for (int r = 0; r < NumRequesters; r++) begin
                if (grant[r]) rsp_data_q[r*DataW +: DataW] <= mem_q[req_bank[r]][req_row[r]];
            end
        end
    end

    // Storage is deliberately left unreset; only active threads are overwritten.
    always_ff @(posedge clk_i) begin
        if (wb_fire) begin
            for (int t = 0; t < WarpWidth; t++) begin
                if (wb_act_mask_i[t])
                    mem_q[wb_bank][wb_row][t*RegWidth +: RegWidth] <= wb_data_i[t*RegWidth +: RegWidth];
            end
        end
    end

endmodule

// File: tb/tb_register_bank_responder.sv
// Directed bench for register_bank_responder in a 2-port, 2-bank, 2-warp, 4-thread setup.
module tb_register_bank_responder;

    localparam logic [127:0] ValR3  = {4{32'hA5A5_0003}};
    localparam logic [127:0] ValR2  = {4{32'hB0B0_0002}};
    localparam logic [127:0] ValR4  = {4{32'hB0B0_0004}};
    localparam logic [127:0] ValR4b = {4{32'hC0C0_0004}};
    localparam logic [127:0] ValMix = {32'h1111_1111, 32'h2222_2222, 32'h1111_1111, 32'h2222_2222};

    logic         clk;
    logic         rst;
    logic [1:0]   reqValid;
    logic [1:0]   reqReady;
    logic [1:0]   reqWid;
    logic [7:0]   reqRegIdx;
    logic [1:0]   rspValid;
    logic [255:0] rspData;
    logic         wbValid;
    logic         wbReady;
    logic         wbWid;
    logic [3:0]   wbRegIdx;
    logic [3:0]   wbActMask;
    logic [127:0] wbData;

    int checks = 0;
    int errors = 0;

    register_bank_responder #(
        .NumRequesters(2), .NumBanks(2), .NumWarps(2),
        .WarpWidth(4), .RegIdxWidth(4), .RegWidth(32)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(reqValid), .req_ready_o(reqReady),
        .req_wid_i(reqWid), .req_reg_idx_i(reqRegIdx),
        .rsp_valid_o(rspValid), .rsp_data_o(rspData),
        .wb_valid_i(wbValid), .wb_ready_o(wbReady),
        .wb_wid_i(wbWid), .wb_reg_idx_i(wbRegIdx),
        .wb_act_mask_i(wbActMask), .wb_data_i(wbData)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic setRead(input int port, input logic valid, input logic wid, input logic [3:0] idx);
        reqValid[port]          = valid;
        reqWid[port]            = wid;
        reqRegIdx[port*4 +: 4]  = idx;
    endtask

    // Issues a single write-back in the current cycle, returning at the next negedge.
    task automatic writeReg(input logic wid, input logic [3:0] idx, input logic [3:0] mask,
                            input logic [127:0] data);
        wbValid = 1'b1; wbWid = wid; wbRegIdx = idx; wbActMask = mask; wbData = data;
        @(negedge clk);
        wbValid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        reqValid = 2'b11; reqWid = '0; reqRegIdx = 8'h42;
        wbValid = 1'b0; wbWid = 1'b0; wbRegIdx = '0; wbActMask = '0; wbData = '0;
        #7;
        checks++; if (rspValid !== 2'b00) begin errors++; $display("[TB] FAIL reset_rsp_valid: got %b want 00", rspValid); end
        checks++; if (reqReady !== 2'b00) begin errors++; $display("[TB] FAIL reset_req_ready: got %b want 00", reqReady); end
        checks++; if (wbReady !== 1'b0) begin errors++; $display("[TB] FAIL reset_wb_ready: got %b want 0", wbReady); end
        checks++; if (rspData !== 256'd0) begin errors++; $display("[TB] FAIL reset_rsp_data: got %h want 0", rspData); end
        @(negedge clk);
        rst = 1'b0; reqValid = 2'b00;
        #1;
        checks++; if (wbReady !== 1'b1) begin errors++; $display("[TB] FAIL wb_ready_idle: got %b want 1", wbReady); end
        @(negedge clk);
    endtask

    task automatic test_write_read;
        writeReg(1'b0, 4'd3, 4'hF, ValR3);
        setRead(0, 1'b1, 1'b0, 4'd3);
        #1;
        checks++; if (reqReady !== 2'b01) begin errors++; $display("[TB] FAIL wr_ready: got %b want 01", reqReady); end
        @(negedge clk);
        checks++; if (rspValid !== 2'b01) begin errors++; $display("[TB] FAIL wr_rsp_valid: got %b want 01", rspValid); end
        checks++; if (rspData[127:0] !== ValR3) begin errors++; $display("[TB] FAIL wr_rsp_data: got %h want %h", rspData[127:0], ValR3); end
        setRead(0, 1'b0, 1'b0, 4'd0);
        @(negedge clk);
        checks++; if (rspValid !== 2'b00) begin errors++; $display("[TB] FAIL wr_rsp_pulse: got %b want 00", rspValid); end
        checks++; if (rspData[127:0] !== ValR3) begin errors++; $display("[TB] FAIL wr_rsp_hold: got %h want %h", rspData[127:0], ValR3); end
    endtask

    task automatic test_masked_write;
        writeReg(1'b1, 4'd2, 4'hF, {4{32'h1111_1111}});
        writeReg(1'b1, 4'd2, 4'b0101, {4{32'h2222_2222}});
        setRead(1, 1'b1, 1'b1, 4'd2);
        #1;
        checks++; if (reqReady !== 2'b10) begin errors++; $display("[TB] FAIL mask_ready: got %b want 10", reqReady); end
        @(negedge clk);
        checks++; if (rspValid !== 2'b10) begin errors++; $display("[TB] FAIL mask_rsp_valid: got %b want 10", rspValid); end
        checks++; if (rspData[255:128] !== ValMix) begin errors++; $display("[TB] FAIL mask_rsp_data: got %h want %h", rspData[255:128], ValMix); end
        setRead(1, 1'b0, 1'b0, 4'd0);
        @(negedge clk);
    endtask

    task automatic test_round_robin;
        logic [1:0] expGrant;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        writeReg(1'b0, 4'd2, 4'hF, ValR2);
        writeReg(1'b0, 4'd4, 4'hF, ValR4);
        setRead(0, 1'b1, 1'b0, 4'd2);
        setRead(1, 1'b1, 1'b0, 4'd4);
        for (int k = 0; k < 4; k++) begin
            expGrant = (k % 2 == 0) ? 2'b01 : 2'b10;
            #1;
            checks++; if (reqReady !== expGrant) begin errors++; $display("[TB] FAIL rr_ready[%0d]: got %b want %b", k, reqReady, expGrant); end
            @(negedge clk);
            checks++; if (rspValid !== expGrant) begin errors++; $display("[TB] FAIL rr_rsp_valid[%0d]: got %b want %b", k, rspValid, expGrant); end
            if (k % 2 == 0) begin
                checks++; if (rspData[127:0] !== ValR2) begin errors++; $display("[TB] FAIL rr_data0[%0d]: got %h want %h", k, rspData[127:0], ValR2); end
            end else begin
                checks++; if (rspData[255:128] !== ValR4) begin errors++; $display("[TB] FAIL rr_data1[%0d]: got %h want %h", k, rspData[255:128], ValR4); end
            end
        end
        setRead(0, 1'b0, 1'b0, 4'd0);
        setRead(1, 1'b0, 1'b0, 4'd0);
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        setRead(0, 1'b1, 1'b0, 4'd2);
        setRead(1, 1'b1, 1'b0, 4'd3);
        for (int k = 0; k < 2; k++) begin
            #1;
            checks++; if (reqReady !== 2'b11) begin errors++; $display("[TB] FAIL par_ready[%0d]: got %b want 11", k, reqReady); end
            @(negedge clk);
            checks++; if (rspValid !== 2'b11) begin errors++; $display("[TB] FAIL par_rsp_valid[%0d]: got %b want 11", k, rspValid); end
            checks++; if (rspData[127:0] !== ValR2) begin errors++; $display("[TB] FAIL par_data0[%0d]: got %h want %h", k, rspData[127:0], ValR2); end
            checks++; if (rspData[255:128] !== ValR3) begin errors++; $display("[TB] FAIL par_data1[%0d]: got %h want %h", k, rspData[255:128], ValR3); end
        end
        setRead(0, 1'b0, 1'b0, 4'd0);
        setRead(1, 1'b0, 1'b0, 4'd0);
        @(negedge clk);
    endtask

    task automatic test_write_priority;
        wbValid = 1'b1; wbWid = 1'b0; wbRegIdx = 4'd4; wbActMask = 4'hF; wbData = ValR4b;
        setRead(0, 1'b1, 1'b0, 4'd2);
        #1;
        checks++; if (reqReady !== 2'b00) begin errors++; $display("[TB] FAIL prio_blocked: got %b want 00", reqReady); end
        @(negedge clk);
        wbValid = 1'b0;
        checks++; if (rspValid !== 2'b00) begin errors++; $display("[TB] FAIL prio_no_rsp: got %b want 00", rspValid); end
        #1;
        checks++; if (reqReady !== 2'b01) begin errors++; $display("[TB] FAIL prio_retry_ready: got %b want 01", reqReady); end
        @(negedge clk);
        checks++; if (rspValid !== 2'b01) begin errors++; $display("[TB] FAIL prio_rsp_valid: got %b want 01", rspValid); end
        checks++; if (rspData[127:0] !== ValR2) begin errors++; $display("[TB] FAIL prio_rsp_data: got %h want %h", rspData[127:0], ValR2); end
        setRead(0, 1'b1, 1'b0, 4'd4);
        #1;
        checks++; if (reqReady !== 2'b01) begin errors++; $display("[TB] FAIL prio_r4_ready: got %b want 01", reqReady); end
        @(negedge clk);
        checks++; if (rspData[127:0] !== ValR4b) begin errors++; $display("[TB] FAIL prio_r4_data: got %h want %h", rspData[127:0], ValR4b); end
        setRead(0, 1'b0, 1'b0, 4'd0);
        @(negedge clk);
    endtask

    task automatic test_reset_drop;
        setRead(1, 1'b1, 1'b0, 4'd3);
        #1;
        checks++; if (reqReady !== 2'b10) begin errors++; $display("[TB] FAIL drop_ready: got %b want 10", reqReady); end
        @(posedge clk);
        #1;
        rst = 1'b1;
        setRead(1, 1'b0, 1'b0, 4'd0);
        #1;
        checks++; if (rspValid !== 2'b00) begin errors++; $display("[TB] FAIL drop_rsp_valid: got %b want 00", rspValid); end
        checks++; if (reqReady !== 2'b00) begin errors++; $display("[TB] FAIL drop_req_ready: got %b want 00", reqReady); end
        checks++; if (wbReady !== 1'b0) begin errors++; $display("[TB] FAIL drop_wb_ready: got %b want 0", wbReady); end
        checks++; if (rspData !== 256'd0) begin errors++; $display("[TB] FAIL drop_rsp_data: got %h want 0", rspData); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++; if (rspValid !== 2'b00) begin errors++; $display("[TB] FAIL drop_after: got %b want 00", rspValid); end
        checks++; if (wbReady !== 1'b1) begin errors++; $display("[TB] FAIL drop_wb_ready_after: got %b want 1", wbReady); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_masked_write();
        test_round_robin();
        test_back_to_back();
        test_write_priority();
        test_reset_drop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/register_bank_responder.md
REGISTER_BANK_RESPONDER -- requirements
Module: register_bank_responder

Interface
REQ-001 SHALL have parameter NumRequesters, default 2: number of read-request ports, one per operand slot.
REQ-002 SHALL have parameter NumBanks, default 2: number of single-ported register banks; power of two, <= 2^RegIdxWidth.
REQ-003 SHALL have parameters NumWarps 8, WarpWidth 32, RegIdxWidth 6, RegWidth 32, with the same meaning as elsewhere in the compute unit.
REQ-004 SHALL derive WidWidth = max(1, clog2(NumWarps)) and BankSel = clog2(NumBanks); the derived values are not to be overridden.
REQ-005 SHALL have clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have rst_i, input, 1 bit: the reset, which is asynchronous and active-high.
REQ-007 SHALL have req_valid_i / req_ready_o, input / output, NumRequesters bits: per-port read-request handshake.
REQ-008 SHALL have req_wid_i, input, NumRequesters x WidWidth: warp id of each request.
REQ-009 SHALL have req_reg_idx_i, input, NumRequesters x RegIdxWidth: register index of each request.
REQ-010 SHALL have rsp_valid_o, output, NumRequesters bits, and rsp_data_o, output, NumRequesters x RegWidth*WarpWidth: read response; there is no backpressure.
REQ-011 SHALL have wb_valid_i / wb_ready_o, input / output, 1 bit each: write-back handshake.
REQ-012 SHALL have wb_wid_i (WidWidth), wb_reg_idx_i (RegIdxWidth), wb_act_mask_i (WarpWidth) and wb_data_i (RegWidth*WarpWidth), all inputs: the write-back fields.

Function
REQ-013 SHALL store NumWarps x 2^RegIdxWidth warp-wide registers split across NumBanks banks.
REQ-014 SHALL map each access to bank = (wid + reg_idx) mod NumBanks, using the low BankSel bits of the sum.
REQ-015 SHALL limit each bank to one access (read or write) per cycle.
REQ-016 SHALL accept a write whenever wb_valid_i=1: wb_ready_o=1 at all times outside reset.
REQ-017 SHALL give a write priority over reads in its target bank; in that cycle every read to that bank gets req_ready_o=0.
REQ-018 SHALL, on an accepted write, update thread t's RegWidth slice only where wb_act_mask_i[t]=1 and leave the other slices unchanged.
REQ-019 SHALL arbitrate reads to a bank not taken by a write using round-robin across requesters, one grant per bank per cycle.
REQ-020 SHALL keep a per-bank pointer (reset 0): grant the lowest-index valid requester >= pointer, wrapping to 0 if none; after a grant, pointer = granted index + 1 mod NumRequesters; unchanged when there is no grant.
REQ-021 SHALL set req_ready_o[r]=1 iff requester r is granted this cycle; this is combinational from the valids and is 0 when req_valid_i[r]=0.
REQ-022 SHALL serialise identical requests from two requesters (same wid and reg_idx) by round-robin order, without merging them.
REQ-023 SHALL assert rsp_valid_o[r] exactly one cycle after a read handshake on port r, for one cycle, with rsp_data_o[r] holding the register contents including every write accepted in earlier cycles.
REQ-024 SHALL keep rsp_data_o[r] stable while rsp_valid_o[r]=0, holding the last response.
REQ-025 SHALL sustain one handshake per port per cycle when there are no bank conflicts.

Reset
REQ-026 SHALL, while rst_i=1 (asynchronously), force rsp_valid_o=0, req_ready_o=0, wb_ready_o=0 and all round-robin pointers=0.
REQ-027 SHALL drop any read handshaken in the cycle before reset asserts, producing no response.
REQ-028 SHALL leave register storage unreset; read data is undefined until the register is written.
REQ-029 SHALL reset rsp_data_o to 0.

Verification (NumRequesters=2, NumBanks=2, NumWarps=2, WarpWidth=4, RegIdxWidth=4, RegWidth=32)
REQ-030 Write wid0 r3 with data {4{32'hA5A5_0003}} and mask 4'hF, then read port0 wid0 r3 -> ready the same cycle, and rsp_valid_o[0]=1 one cycle later with data {4{32'hA5A5_0003}}.
REQ-031 Write wid1 r2 with mask 4'b0101 over a previous value of all 32'h1111_1111, new data all 32'h2222_2222 -> a later read returns threads 0 and 2 = 2222_2222 and threads 1 and 3 = 1111_1111.
REQ-032 Port0 reads wid0 r2 and port1 reads wid0 r4 (both bank 0) in the same cycle, from reset -> port0 granted in cycle N, port1 in N+1; if both are held for 4 cycles the grants alternate 0,1,0,1.
REQ-033 Port0 reads wid0 r2 (bank 0) and port1 reads wid0 r3 (bank 1) -> both ready in the same cycle, and both responses arrive one cycle later.
REQ-034 Write wid0 r4 (bank 0) while port0 reads wid0 r2 (bank 0) -> req_ready_o[0]=0 that cycle; the read is granted the next cycle.
REQ-035 Handshake a read, then assert rst_i for 1 cycle in the next cycle -> rsp_valid_o stays 0 and all ready outputs are 0 during reset.
